// File: rtl/reg_alu_sequencer_pkg.sv
// Shared definitions for the register-file ALU sequencer.
// Contents:
//   WIDTH_DEF / SEL_W_DEF : default operand width and register select width
//   op_e                  : operation encodings seen on the op input
//   state_e               : sequencer states
//   op_is_legal()         : true for every encoding except the reserved one
package reg_alu_sequencer_pkg;

    localparam int WIDTH_DEF = 512;
    localparam int SEL_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        WB_LO = 2'b10,
        WB_HI = 2'b11
    } state_e;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op != OP_ILL);
    endfunction

endpackage

// File: rtl/reg_alu_sequencer_if.sv
// Bus bundle between the sequencer and its environment.
// Groups the register file read outputs (A1..A4), the external load path,
// the operation command, and the register file write port plus status.
//   master : environment side (drives register outputs, loads, commands)
//   slave  : sequencer side (drives write port, busy, done)
interface reg_alu_sequencer_if
    import reg_alu_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
);

    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] A3;
    logic [WIDTH-1:0] A4;

    logic             ext_we;
    logic [SEL_W-1:0] ext_sel;
    logic [WIDTH-1:0] ext_data;

    logic             start;
    logic [1:0]       op;
    logic [SEL_W-1:0] src_a;
    logic [SEL_W-1:0] src_b;
    logic [SEL_W-1:0] dst_lo;
    logic [SEL_W-1:0] dst_hi;

    logic [SEL_W-1:0] sel_reg_write;
    logic [WIDTH-1:0] data_in;
    logic             reg_write_enable;
    logic             busy;
    logic             done;

    modport master (
        output A1, A2, A3, A4,
        output ext_we, ext_sel, ext_data,
        output start, op, src_a, src_b, dst_lo, dst_hi,
        input  sel_reg_write, data_in, reg_write_enable, busy, done
    );

    modport slave (
        input  A1, A2, A3, A4,
        input  ext_we, ext_sel, ext_data,
        input  start, op, src_a, src_b, dst_lo, dst_hi,
        output sel_reg_write, data_in, reg_write_enable, busy, done
    );

endinterface

// File: rtl/seq_mul_shift_add.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : capture a (multiplicand) and b (multiplier), restart count
//   a, b     : WIDTH-bit unsigned operands
//   product  : 2*WIDTH-bit accumulator; final after the step where last=1
//   last     : high during the final (WIDTH-th) iteration
// The accumulator is {hi, lo}: lo starts as the multiplier and is shifted
// out LSB-first while partial sums enter from the top, so after WIDTH
// steps {hi, lo} holds the full product.
module seq_mul_shift_add #(
    parameter int WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [WIDTH:0]   step_s;

    // Partial sum of the current high half and the conditionally added multiplicand.
    always_comb begin
        step_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    end

    // Accumulator, bit counter and run flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            run_q   <= 1'b0;
        end else if (load) begin
            mcand_q <= a;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= b;
            cnt_q   <= {CNT_W{1'b0}};
            run_q   <= 1'b1;
        end else if (run_q) begin
            {hi_q, lo_q} <= {step_s, lo_q[WIDTH-1:1]};
            cnt_q        <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign product = {hi_q, lo_q};
    assign last    = run_q && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/reg_alu_sequencer.sv
// Sequential ADD / SUB / MUL controller in front of a 4 x WIDTH register file.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; aborts any operation in flight
//   bus : slave side of reg_alu_sequencer_if
//         A1..A4 register outputs, ext_* load path, start/op/src/dst command,
//         sel_reg_write/data_in/reg_write_enable write port, busy, done
// Flow: IDLE -> EXEC -> WB_LO -> WB_HI -> IDLE. While IDLE the write port
// passes the external load path through; outside IDLE external loads are
// dropped. The 2*WIDTH result is written low word first, so when both
// destinations match the high word is what remains in the register.
module reg_alu_sequencer
    import reg_alu_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    reg_alu_sequencer_if.slave bus
);

    state_e             state_q;
    state_e             state_d;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SEL_W-1:0]   dst_lo_q;
    logic [SEL_W-1:0]   dst_hi_q;
    logic               done_q;

    logic               accept_s;
    logic               mul_load_s;
    logic               mul_last_s;
    logic [WIDTH-1:0]   a_sel_s;
    logic [WIDTH-1:0]   b_sel_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [2*WIDTH-1:0] result_s;
    logic [SEL_W-1:0]   port_sel_s;
    logic [WIDTH-1:0]   port_data_s;
    logic               port_we_s;

    // Operand selection from the register file outputs (pre-edge values).
    always_comb begin
        case (bus.src_a)
            2'd0:    a_sel_s = bus.A1;
            2'd1:    a_sel_s = bus.A2;
            2'd2:    a_sel_s = bus.A3;
            2'd3:    a_sel_s = bus.A4;
            default: a_sel_s = {WIDTH{1'b0}};
        endcase
        case (bus.src_b)
            2'd0:    b_sel_s = bus.A1;
            2'd1:    b_sel_s = bus.A2;
            2'd2:    b_sel_s = bus.A3;
            2'd3:    b_sel_s = bus.A4;
            default: b_sel_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic and start acceptance.
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        mul_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && op_is_legal(bus.op)) begin
                    accept_s   = 1'b1;
                    mul_load_s = (bus.op == OP_MUL);
                    state_d    = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // ADD/SUB spend one cycle here; MUL waits for its final bit.
                if ((op_q == OP_MUL) && !mul_last_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = WB_LO;
                end
            end
            WB_LO:   state_d = WB_HI;
            WB_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched command fields and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            dst_lo_q <= {SEL_W{1'b0}};
            dst_hi_q <= {SEL_W{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == WB_HI);
            if (accept_s) begin
                op_q     <= op_e'(bus.op);
                a_q      <= a_sel_s;
                b_q      <= b_sel_s;
                dst_lo_q <= bus.dst_lo;
                dst_hi_q <= bus.dst_hi;
            end
        end
    end

    seq_mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load_s),
        .a       (a_sel_s),
        .b       (b_sel_s),
        .product (product_s),
        .last    (mul_last_s)
    );

    // Double-width result: ADD carries into bit WIDTH, SUB sign-fills the
    // high word from the borrow, MUL comes from the shift-add unit.
    always_comb begin
        add_s = {1'b0, a_q} + {1'b0, b_q};
        sub_s = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD:  result_s = {{(WIDTH-1){1'b0}}, add_s};
            OP_SUB:  result_s = {{WIDTH{sub_s[WIDTH]}}, sub_s[WIDTH-1:0]};
            OP_MUL:  result_s = product_s;
            default: result_s = {(2*WIDTH){1'b0}};
        endcase
    end

    // Write-port mux: external loads in IDLE, result words in write-back.
    always_comb begin
        port_sel_s  = {SEL_W{1'b0}};
        port_data_s = {WIDTH{1'b0}};
        port_we_s   = 1'b0;
        if (rst) begin
            port_we_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    port_sel_s  = bus.ext_sel;
                    port_data_s = bus.ext_data;
                    port_we_s   = bus.ext_we;
                end
                WB_LO: begin
                    port_sel_s  = dst_lo_q;
                    port_data_s = result_s[WIDTH-1:0];
                    port_we_s   = 1'b1;
                end
                WB_HI: begin
                    port_sel_s  = dst_hi_q;
                    port_data_s = result_s[2*WIDTH-1:WIDTH];
                    port_we_s   = 1'b1;
                end
                default: port_we_s = 1'b0;
            endcase
        end
    end

    assign bus.sel_reg_write    = port_sel_s;
    assign bus.data_in          = port_data_s;
    assign bus.reg_write_enable = port_we_s;
    assign bus.busy             = (state_q != IDLE);
    assign bus.done             = done_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Self-checking bench for reg_alu_sequencer with a behavioural register file.
module tb_reg_alu_sequencer;
    import reg_alu_sequencer_pkg::*;

    localparam int W       = 512;
    localparam int MUL_LAT = W + 3;
    localparam int AS_LAT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_alu_sequencer_if #(.WIDTH(W), .SEL_W(2)) bus ();

    reg_alu_sequencer #(.WIDTH(W), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file the sequencer writes into.
    logic [W-1:0] rf [4] = '{default: '0};
    always @(posedge clk) begin
        if (bus.reg_write_enable) rf[bus.sel_reg_write] <= bus.data_in;
    end
    assign bus.A1 = rf[0];
    assign bus.A2 = rf[1];
    assign bus.A3 = rf[2];
    assign bus.A4 = rf[3];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: exact 2*W-bit arithmetic on the operand values.
    function automatic logic [2*W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [2*W-1:0] r;
        case (op)
            2'b00:   r = {{W{1'b0}}, a} + {{W{1'b0}}, b};
            2'b01:   r = {((a < b) ? {W{1'b1}} : {W{1'b0}}), a - b};
            default: r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called right after a falling edge: one external load cycle.
    task automatic ext_load(input logic [1:0] sel, input logic [W-1:0] d);
        bus.ext_we   = 1'b1;
        bus.ext_sel  = sel;
        bus.ext_data = d;
        #1;
        check_i("ext_we_mirror", int'(bus.reg_write_enable), 1);
        check_i("ext_sel_mirror", int'(bus.sel_reg_write), int'(sel));
        check("ext_data_mirror", bus.data_in, d);
        @(negedge clk);
        bus.ext_we = 1'b0;
    endtask

    // Issue one operation and follow it to done, checking writes and timing.
    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [1:0] sa, input logic [1:0] sb,
                          input logic [1:0] dl, input logic [1:0] dh,
                          input logic [W-1:0] elo, input logic [W-1:0] ehi,
                          input bit noise, input bit ew,
                          input logic [1:0] es, input logic [W-1:0] ed);
        logic [W-1:0] exp_rf [4];
        int lat, k, done_k, stray, busy_err;
        bit lo_seen, hi_seen;
        lat = (op == 2'b10) ? MUL_LAT : AS_LAT;
        for (int i = 0; i < 4; i++) exp_rf[i] = rf[i];
        if (ew) exp_rf[es] = ed;
        exp_rf[dl] = elo;
        exp_rf[dh] = ehi;
        bus.start = 1'b1; bus.op = op; bus.src_a = sa; bus.src_b = sb;
        bus.dst_lo = dl; bus.dst_hi = dh;
        bus.ext_we = ew; bus.ext_sel = es; bus.ext_data = ed;
        k = 0; done_k = -1; stray = 0; busy_err = 0; lo_seen = 1'b0; hi_seen = 1'b0;
        while (done_k < 0 && k < lat + 8) begin
            @(negedge clk);
            k++;
            if (noise && bus.busy) begin
                bus.start    = 1'($urandom_range(0, 1));
                bus.op       = 2'($urandom_range(0, 3));
                bus.ext_we   = 1'($urandom_range(0, 1));
                bus.ext_sel  = 2'($urandom_range(0, 3));
                bus.ext_data = rand_word();
            end else begin
                bus.start  = 1'b0;
                bus.ext_we = 1'b0;
            end
            #1;
            if (bus.reg_write_enable) begin
                if (k == lat - 2 && !lo_seen) begin
                    lo_seen = 1'b1;
                    check_i({nm, "_lo_sel"}, int'(bus.sel_reg_write), int'(dl));
                    check({nm, "_lo_data"}, bus.data_in, elo);
                end else if (k == lat - 1 && !hi_seen) begin
                    hi_seen = 1'b1;
                    check_i({nm, "_hi_sel"}, int'(bus.sel_reg_write), int'(dh));
                    check({nm, "_hi_data"}, bus.data_in, ehi);
                end else begin
                    stray++;
                end
            end
            if (bus.busy !== (k < lat)) busy_err++;
            if (bus.done) done_k = k;
        end
        check_i({nm, "_done_cycle"}, done_k, lat);
        check_i({nm, "_wb_seen"}, int'({lo_seen, hi_seen}), 3);
        check_i({nm, "_stray_wr"}, stray, 0);
        check_i({nm, "_busy_window"}, busy_err, 0);
        for (int i = 0; i < 4; i++) check({nm, "_rf"}, rf[i], exp_rf[i]);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [1:0]   sa, sb, dl, dh;
        logic [W-1:0] elo;
        logic [W-1:0] ehi;
        bit           noise;
    } vec_t;

    vec_t         vt [8];
    logic [W-1:0] ones, onesm1, top_bit, bit510;
    logic [W-1:0] vals [4];
    logic [W-1:0] snap [4];
    logic [2*W-1:0] r;
    logic [1:0]   rop, rsa, rsb, rdl, rdh, res;
    int           wr, dn, bz;

    initial begin
        ones    = {W{1'b1}};
        onesm1  = {{(W-1){1'b1}}, 1'b0};
        top_bit = {1'b1, {(W-1){1'b0}}};
        bit510  = {2'b01, {(W-2){1'b0}}};
        vt[0] = '{OP_ADD, W'(5), W'(7), 2'd0, 2'd1, 2'd2, 2'd3, W'(12), W'(0), 1'b0};
        vt[1] = '{OP_ADD, ones, ones, 2'd0, 2'd1, 2'd2, 2'd3, onesm1, W'(1), 1'b0};
        vt[2] = '{OP_SUB, W'(3), W'(5), 2'd0, 2'd1, 2'd2, 2'd3, onesm1, ones, 1'b0};
        vt[3] = '{OP_SUB, W'(5), W'(3), 2'd0, 2'd1, 2'd2, 2'd3, W'(2), W'(0), 1'b0};
        vt[4] = '{OP_MUL, ones, ones, 2'd0, 2'd1, 2'd2, 2'd3, W'(1), onesm1, 1'b1};
        vt[5] = '{OP_ADD, W'(9), W'(7), 2'd1, 2'd1, 2'd0, 2'd1, W'(14), W'(0), 1'b0};
        vt[6] = '{OP_ADD, ones, ones, 2'd0, 2'd1, 2'd2, 2'd2, onesm1, W'(1), 1'b0};
        vt[7] = '{OP_MUL, W'(3), top_bit, 2'd1, 2'd1, 2'd0, 2'd3, W'(0), bit510, 1'b1};

        bus.ext_we = 1'b0; bus.ext_sel = 2'd0; bus.ext_data = '0;
        bus.start = 1'b0; bus.op = 2'd0; bus.src_a = 2'd0; bus.src_b = 2'd0;
        bus.dst_lo = 2'd0; bus.dst_hi = 2'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_i("rst_we", int'(bus.reg_write_enable), 0);
        check_i("rst_sel", int'(bus.sel_reg_write), 0);
        check("rst_data", bus.data_in, W'(0));
        check_i("rst_busy", int'(bus.busy), 0);
        check_i("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);

        // External loads, one per cycle
        ext_load(2'd0, W'(5));
        ext_load(2'd1, W'(7));
        ext_load(2'd2, W'(0));
        ext_load(2'd3, W'(0));
        #1;
        check("load_A1", bus.A1, W'(5));
        check("load_A2", bus.A2, W'(7));
        check_i("load_busy", int'(bus.busy), 0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            ext_load(2'd0, vt[i].va);
            ext_load(2'd1, vt[i].vb);
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].sa, vt[i].sb, vt[i].dl, vt[i].dh,
                   vt[i].elo, vt[i].ehi, vt[i].noise, 1'b0, 2'd0, W'(0));
        end

        // Ext write in the start cycle lands but is not seen by the operands
        ext_load(2'd0, W'(100));
        ext_load(2'd1, W'(23));
        run_op("same_cycle_ext", OP_ADD, 2'd0, 2'd1, 2'd2, 2'd3, W'(123), W'(0),
               1'b0, 1'b1, 2'd0, W'(999));

        // Randomized operations against the reference model
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) begin
                vals[i] = rand_word();
                if ($urandom_range(0, 3) == 0) vals[i] = vals[i] >> $urandom_range(1, W - 1);
                ext_load(2'(i), vals[i]);
            end
            rop = (n == 0) ? OP_MUL : 2'($urandom_range(0, 2));
            rsa = 2'($urandom_range(0, 3)); rsb = 2'($urandom_range(0, 3));
            rdl = 2'($urandom_range(0, 3)); rdh = 2'($urandom_range(0, 3));
            res = 2'($urandom_range(0, 3));
            r = ref_result(rop, vals[rsa], vals[rsb]);
            run_op($sformatf("rand%0d", n), rop, rsa, rsb, rdl, rdh, r[W-1:0], r[2*W-1:W],
                   1'b1, 1'($urandom_range(0, 1)), res, rand_word());
        end

        // Reset in the middle of a multiply
        for (int i = 0; i < 4; i++) snap[i] = rf[i];
        bus.start = 1'b1; bus.op = OP_MUL; bus.src_a = 2'd0; bus.src_b = 2'd1;
        bus.dst_lo = 2'd2; bus.dst_hi = 2'd3;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        check_i("abort_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_i("abort_idle", int'(bus.busy), 0);
        wr = 0; dn = 0; bz = 0;
        for (int k = 0; k < MUL_LAT + 8; k++) begin
            @(negedge clk);
            #1;
            if (bus.reg_write_enable) wr++;
            if (bus.done) dn++;
            if (bus.busy) bz++;
        end
        check_i("abort_writes", wr, 0);
        check_i("abort_done", dn, 0);
        check_i("abort_busy_after", bz, 0);
        for (int i = 0; i < 4; i++) check("abort_rf", rf[i], snap[i]);

        // Illegal op: start is ignored
        bus.start = 1'b1; bus.op = OP_ILL;
        wr = 0; dn = 0; bz = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) bus.start = 1'b0;
            #1;
            if (bus.reg_write_enable) wr++;
            if (bus.done) dn++;
            if (bus.busy) bz++;
        end
        check_i("ill_busy", bz, 0);
        check_i("ill_writes", wr, 0);
        check_i("ill_done", dn, 0);

        // Recovery after abort
        r = ref_result(OP_SUB, rf[1], rf[0]);
        run_op("post_abort", OP_SUB, 2'd1, 2'd0, 2'd3, 2'd2, r[W-1:0], r[2*W-1:W],
               1'b0, 1'b0, 2'd0, W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_alu_sequencer.md
Name: reg_alu_sequencer

Overview:
- Sequential arithmetic controller that sits directly upstream of the 4 x 512-bit register file and drives that file's write port.
- Reads two operands from the file outputs A1..A4 and computes ADD, SUB, or unsigned MUL (shift-add, one bit per cycle).
- Writes the 1024-bit result back as two 512-bit words.
- Also arbitrates an external load path onto the same write port, so software and testbenches preload registers through this block.

Parameters:
- WIDTH, 512, operand and register width in bits.
- SEL_W, 2, register select width (4 registers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- A1, A2, A3, A4  in  WIDTH each  register file outputs (index 0..3).
- ext_we  in  1  external load request.
- ext_sel  in  SEL_W  external load target.
- ext_data  in  WIDTH  external load data.
- start  in  1  operation request; sampled only in IDLE.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 illegal.
- src_a, src_b  in  SEL_W each  operand register indices.
- dst_lo, dst_hi  in  SEL_W each  destination indices for the low and high result words.
- sel_reg_write  out  SEL_W  to register file.
- data_in  out  WIDTH  to register file.
- reg_write_enable  out  1  to register file.
- busy  out  1  high from the cycle after start is accepted through the WB_HI cycle.
- done  out  1  one-cycle pulse after the high word is written.

Behaviour:
- Reset, synchronous: state=IDLE, busy=0, done=0, reg_write_enable=0, sel_reg_write=0, data_in=0.
  - Reset mid-operation aborts immediately; no further writes; latched operands are discarded.
- Write-port mux is combinational from state:
  - IDLE: port = {ext_sel, ext_data, ext_we}.
  - WB_LO / WB_HI: port = {dst_lo/dst_hi latched, result word, 1}.
  - EXEC: reg_write_enable=0.
  - ext_we outside IDLE is dropped silently (no queueing).
- Start acceptance (IDLE, start=1, op!=11):
  - At that edge, latch a=A[src_a], b=A[src_b], op, dst_lo, dst_hi; go to EXEC.
  - Operands are the pre-edge register values; an ext write in the same cycle still completes but is not seen by the operands.
  - op=11: start ignored, stay IDLE, no busy.
- States: IDLE -> EXEC -> WB_LO -> WB_HI -> IDLE.
- EXEC:
  - ADD/SUB: exactly 1 cycle.
    - ADD: result = {511'b0, carry, sum[511:0]}.
    - SUB: low = a-b mod 2^WIDTH; high = all ones if a<b (unsigned borrow), else 0.
  - MUL: exactly WIDTH cycles; counter 0..WIDTH-1.
    - Radix-2 shift-add into a 2*WIDTH accumulator, LSB-first on the multiplier.
    - Exits to WB_LO when counter == WIDTH-1.
- WB_LO writes result[WIDTH-1:0] to dst_lo; WB_HI writes result[2*WIDTH-1:WIDTH] to dst_hi.
  - If dst_lo == dst_hi, the high word wins (written last).
- On the WB_HI->IDLE edge: done=1 for one cycle, busy=0.
  - start is acceptable in the same cycle done is high.
- Latency from the start edge to the done cycle: ADD/SUB 4 cycles, MUL WIDTH+3 cycles.
- src_a == src_b is legal (squaring, doubling, zero difference).
- src or dst equal to a destination of the same op is legal: operands are already latched.

Decomposition:
- Shared package holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_ILL=2'b11;
  - state enum IDLE, EXEC, WB_LO, WB_HI;
  - WIDTH/SEL_W defaults.
- One natural sub-module: seq_mul_shift_add. Inputs: clk, rst, load, a, b. Outputs: product[2*WIDTH-1:0], last. It iterates one bit per cycle.
- ADD/SUB and the port mux stay in the top.

Test Plan:
1. Reset then ext loads, one per cycle: ext_we with sel 0..3 = 5, 7, 0, 0 -> write port mirrors ext inputs; A1=5, A2=7; busy=0.
2. ADD src_a=0, src_b=1, dst_lo=2, dst_hi=3 -> WB_LO writes 12 to idx2, WB_HI writes 0 to idx3; done exactly 4 cycles after the start edge.
3. ADD with A1=A2=2^512-1 -> low = 2^512-2, high = 1.
4. SUB with A1=3, A2=5 -> low = 2^512-2, high = all ones; with A1=5, A2=3 -> low = 2, high = 0.
5. MUL with A1=2^512-1, A2=2^512-1 -> low = 1, high = 2^512-2; done at start+515; start and ext_we pulses during busy are ignored (register file unchanged until WB_LO).
6. rst asserted mid-MUL (counter=100) -> next cycle IDLE, no writes, done never pulses; then op=11 with start -> busy stays 0.
